// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder: operands and start in, status and result out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice processes one operand bit per clock, LSB first,
// with its carry recirculated through a flop. Result appears with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             fa_s, fa_c;

  // Full-adder slice on the current LSBs.
  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          carry_d = bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Result fills from the MSB end so bit 0 lands at position 0 after WIDTH shifts.
        res_d   = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == LastBit) begin
          sum_d   = res_d;
          cout_d  = fa_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1 against plain integer addition.
`timescale 1ns/1ns
module tb_serial_adder;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #10 sys_clk = ~sys_clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus8.slave)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus1.slave)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] last8 = '0;
  logic [1:0] last1 = '0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic busy, input logic done,
                        input logic [8:0] res);
    check({tag, " busy"}, 33'(bus8.busy), 33'(busy));
    check({tag, " done"}, 33'(bus8.done), 33'(done));
    check({tag, " sum"},  33'(bus8.sum),  33'(res[7:0]));
    check({tag, " cout"}, 33'(bus8.cout), 33'(res[8]));
  endtask

  // One add on the WIDTH=8 instance; inj_cyc>0 pulses a competing start during RUN.
  task automatic run_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input int inj_cyc);
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(c);
    @(negedge sys_clk);
    bus8.start = 1'b1;
    bus8.op_a  = a;
    bus8.op_b  = b;
    bus8.cin   = c;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge sys_clk);
      if (cyc < 9) check8($sformatf("c%0d", cyc), 1'b1, 1'b0, last8);
      else         check8($sformatf("c%0d", cyc), 1'b0, 1'b1, exp);
      if (cyc == 1) begin
        bus8.start = 1'b0;
        bus8.op_a  = 8'($urandom);
        bus8.op_b  = 8'($urandom);
        bus8.cin   = 1'($urandom);
      end
      if (cyc == inj_cyc) begin
        bus8.start = 1'b1;
        bus8.op_a  = ~a;
        bus8.op_b  = b ^ 8'h3C;
        bus8.cin   = ~c;
      end else if (inj_cyc > 0 && cyc == inj_cyc + 1) begin
        bus8.start = 1'b0;
      end
    end
    last8 = exp;
    @(negedge sys_clk);
    check8("post", 1'b0, 1'b0, last8);
  endtask

  task automatic run_add1(input logic a, input logic b, input logic c);
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(c);
    @(negedge sys_clk);
    bus1.start = 1'b1;
    bus1.op_a  = a;
    bus1.op_b  = b;
    bus1.cin   = c;
    @(negedge sys_clk);
    bus1.start = 1'b0;
    check("w1 c1 busy", 33'(bus1.busy), 33'(1'b1));
    check("w1 c1 done", 33'(bus1.done), 33'(1'b0));
    check("w1 c1 held", 33'({bus1.cout, bus1.sum}), 33'(last1));
    @(negedge sys_clk);
    check("w1 c2 busy", 33'(bus1.busy), 33'(1'b0));
    check("w1 c2 done", 33'(bus1.done), 33'(1'b1));
    check("w1 c2 res",  33'({bus1.cout, bus1.sum}), 33'(exp));
    last1 = exp;
    @(negedge sys_clk);
    check("w1 c3 done", 33'(bus1.done), 33'(1'b0));
  endtask

  initial begin
    bus8.start = 1'b0; bus8.op_a = '0; bus8.op_b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.cin = 1'b0;
    repeat (2) @(negedge sys_clk);
    check8("reset", 1'b0, 1'b0, 9'h000);
    check("w1 reset", 33'({bus1.busy, bus1.done, bus1.cout, bus1.sum}), 33'(0));
    sys_rst_n = 1'b1;

    // Directed cases, including a competing start at cycle 4.
    run_add8(8'hFF, 8'h01, 1'b0, 0);
    run_add8(8'hA5, 8'h5A, 1'b1, 0);
    run_add8(8'h12, 8'h34, 1'b0, 0);
    run_add8(8'h81, 8'h7E, 1'b0, 4);
    run_add8(8'h00, 8'h00, 1'b0, 0);
    run_add8(8'hFF, 8'hFF, 1'b1, 0);

    // Asynchronous reset in cycle 5 of an add.
    @(negedge sys_clk);
    bus8.start = 1'b1; bus8.op_a = 8'hC3; bus8.op_b = 8'h77; bus8.cin = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) bus8.start = 1'b0;
    end
    #2 sys_rst_n = 1'b0;
    #1 check8("async rst", 1'b0, 1'b0, 9'h000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    last8 = '0;
    last1 = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge sys_clk);
      check8($sformatf("after rst %0d", cyc), 1'b0, 1'b0, 9'h000);
    end

    // Start held high: one add per 10 cycles.
    @(negedge sys_clk);
    bus8.start = 1'b1; bus8.op_a = 8'h9C; bus8.op_b = 8'hB7; bus8.cin = 1'b1;
    for (int cyc = 1; cyc < 30; cyc++) begin
      @(negedge sys_clk);
      if (cyc % 10 == 9) begin
        last8 = 9'h09C + 9'h0B7 + 9'h001;
        check8($sformatf("held c%0d", cyc), 1'b0, 1'b1, last8);
      end else begin
        check8($sformatf("held c%0d", cyc), (cyc % 10) != 0, 1'b0, last8);
      end
    end
    @(negedge sys_clk);
    bus8.start = 1'b0;
    check8("held end", 1'b0, 1'b0, last8);

    // WIDTH=1: all combinations, then random.
    for (int i = 0; i < 8; i++) begin
      run_add1(1'(i >> 2), 1'(i >> 1), 1'(i));
    end

    for (int i = 0; i < 200; i++) begin
      run_add8(8'($urandom), 8'($urandom), 1'($urandom), 0);
      if (i % 10 == 0) run_add1(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
